// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared types and constants for the nibble-serial add/subtract sequencer.
package nibble_serial_add_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int NIBBLE_W  = 4;
  localparam int MIN_WIDTH = 8;

  // Operand width must split into whole nibbles and span at least two of them.
  function automatic bit width_ok(input int w);
    return ((w % NIBBLE_W) == 0) && (w >= MIN_WIDTH);
  endfunction

endpackage

// File: rtl/adder4.sv
// 4-bit ripple adder slice shared by the nibble-serial sequencer.
module adder4 (
  input  logic [3:0] in_a,
  input  logic [3:0] in_b,
  input  logic       in_c,
  output logic       out_c,
  output logic [3:0] out_sum
);

  assign {out_c, out_sum} = {1'b0, in_a} + {1'b0, in_b} + {4'b0000, in_c};

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// WIDTH-bit add/subtract computed one nibble per clock through a single adder4 slice.
// Optional macro ADD_CTRL_B2B_EN: a start seen in DONE is accepted directly (DONE->RUN).
//
// Handshake: in_start is sampled on a rising edge only while the block can accept
// (IDLE, or DONE when ADD_CTRL_B2B_EN is defined); out_busy is high from the cycle
// after accept through the DONE cycle; out_done pulses for one cycle in DONE, when
// out_sum/out_c/out_ovf are valid. Starts seen while not accepting are dropped.
module nibble_serial_add_ctrl
  import nibble_serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             in_clk,
  input  logic             in_rst,
  input  logic             in_start,
  input  logic             in_sub,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_c,
  output logic             out_busy,
  output logic             out_done,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_c,
  output logic             out_ovf,
  output logic [1:0]       out_state
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

`ifdef ADD_CTRL_B2B_EN
  localparam bit B2B_EN = 1'b1;
`else
  localparam bit B2B_EN = 1'b0;
`endif

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("nibble_serial_add_ctrl: WIDTH must be a multiple of 4 and at least 8");
  end

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             busy_q, done_q, c_q, ovf_q;

  logic [3:0] slice_a, slice_b, slice_sum;
  logic       slice_c;
  logic       accept;

  assign slice_a = a_q[NIBBLE_W*int'(idx_q) +: NIBBLE_W];
  assign slice_b = b_q[NIBBLE_W*int'(idx_q) +: NIBBLE_W];

  adder4 u_slice (
    .in_a    (slice_a),
    .in_b    (slice_b),
    .in_c    (carry_q),
    .out_c   (slice_c),
    .out_sum (slice_sum)
  );

  assign accept = in_start &&
                  ((state_q == ST_IDLE) || (B2B_EN && (state_q == ST_DONE)));

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      c_q     <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        // Subtract is A + ~B + 1, so the carry register carries the +1.
        a_q     <= in_a;
        b_q     <= in_sub ? ~in_b : in_b;
        carry_q <= in_sub | in_c;
        idx_q   <= '0;
        sum_q   <= '0;
        c_q     <= 1'b0;
        ovf_q   <= 1'b0;
        busy_q  <= 1'b1;
        state_q <= ST_RUN;
      end else begin
        case (state_q)
          ST_RUN: begin
            sum_q[NIBBLE_W*int'(idx_q) +: NIBBLE_W] <= slice_sum;
            carry_q <= slice_c;
            if (idx_q == IDX_LAST) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              c_q     <= slice_c;
              ovf_q   <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_sum[3] != a_q[WIDTH-1]);
              idx_q   <= '0;
            end else begin
              idx_q <= idx_q + IDX_ONE;
            end
          end
          ST_DONE: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign out_busy  = busy_q;
  assign out_done  = done_q;
  assign out_sum   = sum_q;
  assign out_c     = c_q;
  assign out_ovf   = ovf_q;
  assign out_state = state_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Self-checking bench for nibble_serial_add_ctrl (WIDTH=16); B2B case built when ADD_CTRL_B2B_EN is defined.
module tb_nibble_serial_add_ctrl;

  localparam int WIDTH   = 16;
  localparam int NIBBLES = WIDTH / 4;
  localparam int TIMEOUT = 20;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             sub = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             busy, done, c_out, ovf;
  logic [WIDTH-1:0] sum;
  logic [1:0]       dbg_state;

  logic [WIDTH+1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int exp_dones = 0;

  nibble_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .in_clk    (clk),
    .in_rst    (rst),
    .in_start  (start),
    .in_sub    (sub),
    .in_a      (a),
    .in_b      (b),
    .in_c      (cin),
    .out_busy  (busy),
    .out_done  (done),
    .out_sum   (sum),
    .out_c     (c_out),
    .out_ovf   (ovf),
    .out_state (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: plain integer arithmetic; result packed as {ovf, carry, sum}.
  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                                             input logic tsub, input logic tc);
    longint lim = longint'(1) << (WIDTH - 1);
    longint ua = longint'(ta);
    longint ub = longint'(tb);
    longint sa = (ua >= lim) ? ua - 2 * lim : ua;
    longint sb = (ub >= lim) ? ub - 2 * lim : ub;
    longint raw = tsub ? (ua - ub + 2 * lim) : (ua + ub + longint'(tc));
    longint sres = tsub ? (sa - sb) : (sa + sb + longint'(tc));
    logic   v = (sres < -lim) || (sres > lim - 1);
    return {v, raw[WIDTH], raw[WIDTH-1:0]};
  endfunction

  task automatic drive_inputs(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                              input logic tsub, input logic tc);
    a = ta; b = tb; sub = tsub; cin = tc;
  endtask

  task automatic scramble_inputs();
    drive_inputs(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic check_result(input string tag);
    logic [WIDTH+1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_q_empty"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_sum"}, 64'(sum),   64'(e[WIDTH-1:0]));
      check({tag, "_c"},   64'(c_out), 64'(e[WIDTH]));
      check({tag, "_ovf"}, 64'(ovf),   64'(e[WIDTH+1]));
    end
  endtask

  // Drives one request; extra_at>0 pulses a stray start that many cycles after accept.
  task automatic run_op(input string tag, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                        input logic tsub, input logic tc, input int extra_at);
    int lat = 0;
    int d0;
    @(negedge clk);
    drive_inputs(ta, tb, tsub, tc);
    start = 1'b1;
    exp_q.push_back(model(ta, tb, tsub, tc));
    exp_dones++;
    d0 = done_cnt;
    while (lat < TIMEOUT) begin
      @(negedge clk);
      lat++;
      if (lat == 1 || lat == extra_at + 1) begin
        start = 1'b0;
        scramble_inputs();
      end
      if (lat == 1) check({tag, "_busy"}, 64'(busy), 64'd1);
      if (extra_at > 0 && lat == extra_at) begin
        scramble_inputs();
        start = 1'b1;
      end
      if (done === 1'b1) break;
    end
    check({tag, "_latency"}, 64'(lat), 64'(NIBBLES + 1));
    check({tag, "_busy_done"}, 64'(busy), 64'd1);
    check_result(tag);
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    repeat (NIBBLES + 2) @(negedge clk);
    check({tag, "_done_count"}, 64'(done_cnt - d0), 64'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy",  64'(busy),      64'd0);
    check("rst_done",  64'(done),      64'd0);
    check("rst_sum",   64'(sum),       64'd0);
    check("rst_c",     64'(c_out),     64'd0);
    check("rst_ovf",   64'(ovf),       64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    rst = 1'b0;

    run_op("add_00ff", 16'h00FF, 16'h0001, 1'b0, 1'b0, 0);
    run_op("add_ffff", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    run_op("add_7fff", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
    run_op("sub_8000", 16'h8000, 16'h0001, 1'b1, 1'b0, 0);
    run_op("sub_0001", 16'h0001, 16'h0002, 1'b1, 1'b1, 0);
    run_op("add_cin",  16'h7FFF, 16'h0000, 1'b0, 1'b1, 0);
    run_op("ignore",   16'h1234, 16'h4321, 1'b0, 1'b0, 2);

    // Reset during the second RUN cycle: partial result dropped, no done.
    begin
      int d0;
      @(negedge clk);
      drive_inputs(16'hABCD, 16'h1111, 1'b0, 1'b1);
      start = 1'b1;
      d0 = done_cnt;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_busy",  64'(busy),      64'd0);
      check("midrst_done",  64'(done),      64'd0);
      check("midrst_sum",   64'(sum),       64'd0);
      check("midrst_c",     64'(c_out),     64'd0);
      check("midrst_ovf",   64'(ovf),       64'd0);
      check("midrst_state", 64'(dbg_state), 64'd0);
      repeat (NIBBLES + 3) @(negedge clk);
      check("midrst_no_done", 64'(done_cnt - d0), 64'd0);
    end
    run_op("after_rst", 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 0);

    for (int i = 0; i < 30; i++) begin
      run_op("rand", WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, NIBBLES - 1)) : 0);
    end

`ifdef ADD_CTRL_B2B_EN
    begin
      int lat;
      logic [WIDTH-1:0] na, nb;
      @(negedge clk);
      drive_inputs(16'h1000, 16'h0234, 1'b0, 1'b0);
      start = 1'b1;
      exp_q.push_back(model(16'h1000, 16'h0234, 1'b0, 1'b0));
      exp_dones++;
      lat = 0;
      while (lat < TIMEOUT) begin
        @(negedge clk);
        lat++;
        if (lat == 1) start = 1'b0;
        if (done === 1'b1) break;
      end
      check("b2b_first_latency", 64'(lat), 64'(NIBBLES + 1));
      check_result("b2b_first");
      na = WIDTH'($urandom);
      nb = WIDTH'($urandom);
      drive_inputs(na, nb, 1'b1, 1'b0);
      start = 1'b1;
      exp_q.push_back(model(na, nb, 1'b1, 1'b0));
      exp_dones++;
      lat = 0;
      while (lat < TIMEOUT) begin
        @(negedge clk);
        lat++;
        if (lat == 1) begin
          start = 1'b0;
          check("b2b_busy_held", 64'(busy), 64'd1);
        end
        if (done === 1'b1) break;
      end
      check("b2b_second_latency", 64'(lat), 64'(NIBBLES + 1));
      check_result("b2b_second");
      repeat (NIBBLES + 2) @(negedge clk);
    end
`endif

    check("total_dones", 64'(done_cnt), 64'(exp_dones));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
